// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the fifo1 write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One fifo1 word carries one 10-byte packet.
  localparam int PKT_BYTES = 10;
  localparam int PKT_DSIZE = PKT_BYTES * 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshakes plus the fifo1 write port, bundled for the arbiter.
// The master side is the environment (packet sources and fifo1 full flag);
// the slave side is the arbiter itself.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = PKT_DSIZE
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;

  modport master (
    output req_valid,
    output req_data,
    output wfull,
    input  req_ready,
    input  winc,
    input  wdata
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  wfull,
    output req_ready,
    output winc,
    output wdata
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: returns the first asserted request found when
// scanning start, start+1, ... modulo NREQ.
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] start,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  // Walk from the farthest offset back toward start so the nearest request wins.
  always_comb begin
    int pos;
    pos = 0;
    any = |req;
    idx = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (req[IW'(pos)]) begin
        idx = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo1 write port between NREQ packet
// sources. A grant lasts for up to BURST accepted packets or until the
// granted source withdraws valid; a full fifo stalls but never releases it.
// Every grant is preceded by one IDLE arbitration cycle.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = PKT_DSIZE,
  parameter int BURST = 4,
  parameter int CW    = 16
) (
  input  logic                    wclk,
  input  logic                    rst,
  fifo_wr_arbiter_if.slave        bus,
  output logic                    gnt_active,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [CW-1:0]           pkt_count,
  output logic [CW-1:0]           full_stall_count
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic            sel_valid;
  logic [DSIZE-1:0] sel_data;
  logic            xfer;
  logic            stall;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req   (bus.req_valid),
    .start (rr_ptr_q),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  // Select the granted source's valid and packet; the data path is shared
  // with IDLE, where it is simply ignored because winc stays low.
  always_comb begin
    sel_valid = bus.req_valid[0];
    sel_data  = bus.req_data[DSIZE-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id_q == IW'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_data  = bus.req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // FSM next state, grant bookkeeping, handshake outputs and statistics.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    burst_cnt_d = burst_cnt_q;
    xfer        = 1'b0;
    stall       = 1'b0;
    bus.req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_id_d    = pick_idx;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Ready reflects only fifo space so a source may present valid any time.
        for (int i = 0; i < NREQ; i++) begin
          bus.req_ready[i] = (gnt_id_q == IW'(i)) && !bus.wfull;
        end
        xfer  = sel_valid && !bus.wfull;
        stall = sel_valid && bus.wfull;
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
          if (burst_cnt_q == BW'(BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(gnt_id_q);
          end
        end else if (!sel_valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(gnt_id_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pkt_cnt_d   = xfer  ? sat_inc(pkt_cnt_q)   : pkt_cnt_q;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // Register all arbiter state; reset forces an immediate return to IDLE.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      burst_cnt_q <= '0;
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      burst_cnt_q <= burst_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.winc         = xfer;
  assign bus.wdata        = sel_data;
  assign gnt_active       = (state_q == GRANT);
  assign gnt_id           = gnt_id_q;
  assign pkt_count        = pkt_cnt_q;
  assign full_stall_count = stall_cnt_q;

endmodule
